clk_rst_seq: RTL and testbench
==============================

# clk_rst_seq

Reset and timing-strobe sequencer that sits directly downstream of the 25→100 MHz PLL in the FPGA RHS driver, clocked by the PLL's `global_clock`. It holds the rest of the design in reset until the PLL output has run for a fixed settle interval, then releases it. After release it generates the single-cycle clock-enable strobes (SPI bit rate, sample-frame rate) that the RHS SPI engine and channel sequencer consume. It also keeps a wrapping frame counter for timestamping.

## Interface
- `SETTLE_CYCLES`, 1024: number of `clock_in` cycles that `sys_reset` is held after reset or a restart request; must be ≥1.
- `SCLK_DIV`, 4: period of `sclk_en` in `clock_in` cycles; must be ≥2.
- `FRAME_DIV`, 3125: period of `frame_tick` in `clock_in` cycles (32 kHz at 100 MHz); must be ≥2.

Ports:
- `clock_in`  in  1  system clock; PLL `global_clock`, 100 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `ext_rst_req`  in  1  level; restarts the settle sequence.
- `pause`  in  1  level; freezes both dividers and suppresses strobes.
- `sys_reset`  out  1  synchronous reset for downstream logic, active high.
- `run`  out  1  high while in RUN.
- `sclk_en`  out  1  one-cycle strobe every `SCLK_DIV` unpaused RUN cycles.
- `frame_tick`  out  1  one-cycle strobe every `FRAME_DIV` unpaused RUN cycles.
- `frame_count`  out  16  count of `frame_tick` pulses; wraps.

## Operation
- FSM states are SETTLE and RUN. All outputs are registered.
- Reset values:
  - state = SETTLE, settle counter = 0, both dividers = 0.
  - `sys_reset` = 1, `run` = 0, `sclk_en` = 0, `frame_tick` = 0, `frame_count` = 0.
- SETTLE:
  - The settle counter increments each cycle.
  - When the counter equals `SETTLE_CYCLES`-1, go to RUN: `sys_reset`←0, `run`←1, dividers←0.
  - `ext_rst_req`=1 in SETTLE forces the settle counter back to 0.
- RUN:
  - `ext_rst_req`=1 → SETTLE: `sys_reset`←1, `run`←0, settle counter←0, dividers←0, strobes←0. `frame_count` is not cleared.
  - Otherwise, if `pause`=0, each divider increments. On reaching DIV-1, the divider wraps to 0 and its strobe is asserted on the next cycle.
  - If `pause`=1, the dividers hold and the strobes are 0. Counting resumes from the held value.
- `frame_count` increments, mod 2^16, in the same cycle `frame_tick` is high. 0xFFFF wraps to 0x0000.
- Priority: `reset` > `ext_rst_req` > `pause`.
- Counter widths: $clog2 of the respective parameter, minimum 1.

## Timing
- After the last cycle with `reset`=1, `sys_reset` stays 1 for exactly `SETTLE_CYCLES` cycles. It falls, and `run` rises, on the same edge.
- RUN cycles are numbered from 1 at the first cycle `run`=1:
  - `sclk_en` is high on unpaused RUN cycles k·`SCLK_DIV`+1 (k ≥ 1).
  - `frame_tick` is high on unpaused RUN cycles k·`FRAME_DIV`+1.
  - In other words, the strobe appears one cycle after the divider wrap.
- A divider wrap in the last cycle before `pause` rises: that strobe is still issued, and counts toward `frame_count`.
- `ext_rst_req` sampled high at edge n: `sys_reset`=1 and `run`=0 from cycle n+1. A strobe pending for n+1 is dropped.
- `ext_rst_req` held high: the block stays in SETTLE with counter 0. The settle interval starts counting after it falls.
- `reset` mid-RUN: every output returns to its reset value on the next edge, including `frame_count`.

## Structure
- Package `clk_rst_pkg`:
  - state enum `seq_state_t` {SETTLE, RUN}.
  - `FRAME_CNT_W` = 16.
- Sub-module `tick_div`:
  - Parameter `DIV`.
  - Inputs `clock_in`, `reset`, `clr`, `en`; output `pulse`.
  - Registered one-cycle pulse, one cycle after wrap.
  - Instantiated twice: SCLK and FRAME.
- The top level holds the FSM, the settle counter and `frame_count`.

## Test plan
All scenarios use SETTLE_CYCLES=16, SCLK_DIV=4, FRAME_DIV=10.
- **Power-up:** `reset` high 3 cycles, then low → `sys_reset`=1 for exactly 16 cycles. `run` rises on the same edge `sys_reset` falls. No strobes before then.
- **Strobe cadence:** 40 unpaused RUN cycles → `sclk_en` on RUN cycles 5, 9, 13, …, 37; `frame_tick` on 11, 21, 31; `frame_count`=3. Each pulse is exactly 1 cycle wide.
- **Pause:** `pause`=1 for RUN cycles 7–12 → no strobes during the pause. Next `sclk_en` on cycle 13+2=15, since the divider resumes at 2. Next `frame_tick` on cycle 17.
- **Restart:** `ext_rst_req` pulsed 1 cycle at RUN cycle 25 → `sys_reset`=1 for 16 cycles from cycle 26. `frame_count` stays 2. The strobe cadence restarts from RUN cycle 1.
- **Wrap:** preload `frame_count`=0xFFFE by forcing, run 2 frames → reads 0xFFFF, then 0x0000.
- **Priority:** `ext_rst_req` and `pause` high together in RUN → block enters SETTLE. `reset` asserted mid-SETTLE with `ext_rst_req` high → all outputs at reset values.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg
// Shared types and constants for the reset / strobe sequencer.
//   seq_state_t  : sequencer FSM states (SETTLE, RUN)
//   FRAME_CNT_W  : width of the wrapping frame counter
//   cnt_width()  : counter width for a modulus n, never less than 1 bit
package clk_rst_pkg;

    typedef enum logic [0:0] {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } seq_state_t;

    localparam int unsigned FRAME_CNT_W = 16;

    // $clog2 of the modulus, clamped to 1 so a modulus of 1 still gets a bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_rst_seq_tick_div.sv
// tick_div
// Free-running modulo-DIV divider with a registered single-cycle strobe.
// The strobe is high for one cycle, one cycle after the divider wraps.
// Ports:
//   clock_in : system clock
//   reset    : synchronous, active-high reset
//   clr      : synchronous clear of the divider and any pending strobe
//   en       : advance the divider this cycle
//   pulse    : one-cycle strobe (registered)
module tick_div
    import clk_rst_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clock_in,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic pulse
);

    localparam int unsigned CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    // Next divider value; the strobe is set on the wrap and emitted next cycle.
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d   = '0;
                pulse_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Divider and strobe registers.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/clk_rst_seq.sv
// clk_rst_seq
// Reset and timing-strobe sequencer downstream of the PLL. Holds sys_reset
// for SETTLE_CYCLES after reset or a restart request, then enters RUN and
// emits the SPI bit-rate strobe (sclk_en) and the sample-frame strobe
// (frame_tick), plus a wrapping count of frame_tick pulses.
// Parameters: SETTLE_CYCLES >= 1, SCLK_DIV >= 2, FRAME_DIV >= 2.
// Ports:
//   clock_in    : system clock (PLL global_clock)
//   reset       : synchronous, active-high reset
//   ext_rst_req : level, restarts the settle sequence
//   pause       : level, freezes both dividers while in RUN
//   sys_reset   : downstream synchronous reset, active high
//   run         : high while in RUN
//   sclk_en     : one-cycle strobe every SCLK_DIV unpaused RUN cycles
//   frame_tick  : one-cycle strobe every FRAME_DIV unpaused RUN cycles
//   frame_count : count of frame_tick pulses, wraps mod 2^16
module clk_rst_seq
    import clk_rst_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned SCLK_DIV      = 4,
    parameter int unsigned FRAME_DIV     = 3125
) (
    input  logic                   clock_in,
    input  logic                   reset,
    input  logic                   ext_rst_req,
    input  logic                   pause,
    output logic                   sys_reset,
    output logic                   run,
    output logic                   sclk_en,
    output logic                   frame_tick,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int unsigned SW = cnt_width(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    seq_state_t             state_q, state_d;
    logic [SW-1:0]          settle_q, settle_d;
    logic                   sys_reset_q, sys_reset_d;
    logic                   run_q, run_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic                   div_clr_c;
    logic                   div_en_c;
    logic                   sclk_pulse;
    logic                   frame_pulse;

    // Next-state, settle counter and divider control.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        sys_reset_d = sys_reset_q;
        run_d       = run_q;
        div_clr_c   = 1'b0;
        div_en_c    = 1'b0;
        // A tick already on the output is counted even if a restart drops
        // the next one.
        frame_count_d = frame_pulse ? frame_count_q + FRAME_CNT_W'(1) : frame_count_q;

        case (state_q)
            SETTLE: begin
                // Dividers stay cleared so RUN always starts from phase 0.
                div_clr_c = 1'b1;
                if (ext_rst_req) begin
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d     = RUN;
                    settle_d    = '0;
                    sys_reset_d = 1'b0;
                    run_d       = 1'b1;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            RUN: begin
                if (ext_rst_req) begin
                    // Clearing the dividers also drops any strobe pending for the next cycle.
                    state_d     = SETTLE;
                    settle_d    = '0;
                    sys_reset_d = 1'b1;
                    run_d       = 1'b0;
                    div_clr_c   = 1'b1;
                end else begin
                    div_en_c = ~pause;
                end
            end
            default: begin
                state_d     = SETTLE;
                settle_d    = '0;
                sys_reset_d = 1'b1;
                run_d       = 1'b0;
                div_clr_c   = 1'b1;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q       <= SETTLE;
            settle_q      <= '0;
            sys_reset_q   <= 1'b1;
            run_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            sys_reset_q   <= sys_reset_d;
            run_q         <= run_d;
            frame_count_q <= frame_count_d;
        end
    end

    // SPI bit-rate strobe.
    tick_div #(
        .DIV (SCLK_DIV)
    ) u_sclk_div (
        .clock_in (clock_in),
        .reset    (reset),
        .clr      (div_clr_c),
        .en       (div_en_c),
        .pulse    (sclk_pulse)
    );

    // Sample-frame strobe.
    tick_div #(
        .DIV (FRAME_DIV)
    ) u_frame_div (
        .clock_in (clock_in),
        .reset    (reset),
        .clr      (div_clr_c),
        .en       (div_en_c),
        .pulse    (frame_pulse)
    );

    assign sys_reset   = sys_reset_q;
    assign run         = run_q;
    assign sclk_en     = sclk_pulse;
    assign frame_tick  = frame_pulse;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb_clk_rst_seq
// Self-checking bench for clk_rst_seq with SETTLE_CYCLES=16, SCLK_DIV=4,
// FRAME_DIV=10. Expected strobe cycles (RUN-cycle numbers) are queued before
// each scenario and popped as the DUT raises its strobes.
module tb_clk_rst_seq;
    import clk_rst_pkg::*;

    localparam int unsigned SETTLE_N = 16;
    localparam int unsigned SDIV     = 4;
    localparam int unsigned FDIV     = 10;

    logic                   clock_in = 1'b0;
    logic                   reset;
    logic                   ext_rst_req;
    logic                   pause;
    logic                   sys_reset;
    logic                   run;
    logic                   sclk_en;
    logic                   frame_tick;
    logic [FRAME_CNT_W-1:0] frame_count;

    int checks   = 0;
    int failures = 0;
    int rc       = 0;   // RUN-cycle number of the current cycle, 0 outside RUN
    int sclk_q[$];
    int frame_q[$];

    always #5 clock_in = ~clock_in;

    clk_rst_seq #(
        .SETTLE_CYCLES (SETTLE_N),
        .SCLK_DIV      (SDIV),
        .FRAME_DIV     (FDIV)
    ) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .ext_rst_req (ext_rst_req),
        .pause       (pause),
        .sys_reset   (sys_reset),
        .run         (run),
        .sclk_en     (sclk_en),
        .frame_tick  (frame_tick),
        .frame_count (frame_count)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, score strobes mid-cycle, advance to next cycle.
    task automatic drive_cycle(input logic ext, input logic pse);
        ext_rst_req = ext;
        pause       = pse;
        @(negedge clock_in);
        if (sclk_en) begin
            if (sclk_q.size() == 0) chk_eq("sclk_unexpected", {31'b0, sclk_en}, 32'd0);
            else                    chk_eq("sclk_cycle", 32'(rc), 32'(sclk_q.pop_front()));
        end
        if (frame_tick) begin
            if (frame_q.size() == 0) chk_eq("frame_unexpected", {31'b0, frame_tick}, 32'd0);
            else                     chk_eq("frame_cycle", 32'(rc), 32'(frame_q.pop_front()));
        end
        @(posedge clock_in);
        #1;
        rc = run ? rc + 1 : 0;
    endtask

    // Hold reset for n edges (with ext_rst_req as given), then check reset values.
    task automatic apply_reset(input int n, input logic ext, input string tag);
        reset       = 1'b1;
        ext_rst_req = ext;
        pause       = 1'b0;
        repeat (n) @(posedge clock_in);
        #1;
        chk_eq({tag, "_sys_reset"}, {31'b0, sys_reset}, 32'd1);
        chk_eq({tag, "_outs"}, {29'b0, run, sclk_en, frame_tick}, 32'd0);
        chk_eq({tag, "_frame_count"}, 32'(frame_count), 32'd0);
        reset       = 1'b0;
        ext_rst_req = 1'b0;
        rc          = 0;
    endtask

    // Count sys_reset cycles from the current one; expect SETTLE_N then run.
    task automatic wait_settle(input string tag);
        int n;
        n           = 0;
        ext_rst_req = 1'b0;
        pause       = 1'b0;
        while (sys_reset === 1'b1 && n < 64) begin
            chk_eq({tag, "_quiet"}, {29'b0, run, sclk_en, frame_tick}, 32'd0);
            n++;
            @(posedge clock_in);
            #1;
        end
        chk_eq({tag, "_len"}, 32'(n), 32'(SETTLE_N));
        chk_eq({tag, "_run_rise"}, {31'b0, run}, 32'd1);
        rc = run ? 1 : 0;
    endtask

    task automatic drain(input string tag);
        chk_eq({tag, "_sclk_missing"}, 32'(sclk_q.size()), 32'd0);
        chk_eq({tag, "_frame_missing"}, 32'(frame_q.size()), 32'd0);
        sclk_q.delete();
        frame_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        ext_rst_req = 1'b0;
        pause       = 1'b0;

        // Power-up
        apply_reset(3, 1'b0, "por");
        wait_settle("por");

        // Strobe cadence over 40 unpaused RUN cycles
        for (int c = 5; c <= 37; c += 4) sclk_q.push_back(c);
        frame_q.push_back(11);
        frame_q.push_back(21);
        frame_q.push_back(31);
        repeat (40) drive_cycle(1'b0, 1'b0);
        drain("cad");
        chk_eq("cad_frame_count", 32'(frame_count), 32'd3);

        // Pause 7-12, then pause 19-22 right after an sclk wrap at 18
        apply_reset(3, 1'b0, "rst_p");
        wait_settle("pause_settle");
        sclk_q.push_back(5);
        sclk_q.push_back(15);
        sclk_q.push_back(19);
        frame_q.push_back(17);
        for (int i = 0; i < 26; i++)
            drive_cycle(1'b0, (rc >= 7 && rc <= 12) || (rc >= 19 && rc <= 22));
        drain("pause");
        chk_eq("pause_frame_count", 32'(frame_count), 32'd1);

        // Restart pulse at RUN cycle 25
        apply_reset(3, 1'b0, "rst_r");
        wait_settle("restart_settle");
        for (int c = 5; c <= 25; c += 4) sclk_q.push_back(c);
        frame_q.push_back(11);
        frame_q.push_back(21);
        for (int i = 0; i < 25; i++) drive_cycle(rc == 25, 1'b0);
        drain("restart");
        chk_eq("restart_sys_reset", {31'b0, sys_reset}, 32'd1);
        chk_eq("restart_frame_kept", 32'(frame_count), 32'd2);
        wait_settle("restart_resettle");
        chk_eq("restart_frame_kept2", 32'(frame_count), 32'd2);

        // Cadence restarts at RUN cycle 1; restart at 16 drops the sclk due at 17
        sclk_q.push_back(5);
        sclk_q.push_back(9);
        sclk_q.push_back(13);
        frame_q.push_back(11);
        for (int i = 0; i < 16; i++) drive_cycle(rc == 16, 1'b0);
        drain("recad");
        chk_eq("recad_frame_count", 32'(frame_count), 32'd3);
        wait_settle("drop_settle");

        // Reset mid-RUN clears frame_count
        repeat (3) drive_cycle(1'b0, 1'b0);
        apply_reset(1, 1'b0, "midrun");

        // frame_count wrap
        wait_settle("wrap_settle");
        for (int c = 5; c <= 21; c += 4) sclk_q.push_back(c);
        frame_q.push_back(11);
        frame_q.push_back(21);
        for (int i = 0; i < 21; i++) begin
            if (rc == 2) begin
                force dut.frame_count_q = 16'hFFFE;
                drive_cycle(1'b0, 1'b0);
                release dut.frame_count_q;
            end else begin
                drive_cycle(1'b0, 1'b0);
            end
            if (rc == 12) chk_eq("wrap_ffff", 32'(frame_count), 32'h0000_FFFF);
        end
        chk_eq("wrap_zero", 32'(frame_count), 32'd0);
        drain("wrap");

        // Priority: ext_rst_req with pause, held ext, then reset with ext high
        apply_reset(3, 1'b0, "rst_pri");
        wait_settle("pri_settle");
        sclk_q.push_back(5);
        sclk_q.push_back(9);
        frame_q.push_back(11);
        for (int i = 0; i < 12; i++) drive_cycle(rc == 12, rc == 12);
        chk_eq("pri_enter_settle", {30'b0, sys_reset, run}, 32'd2);
        chk_eq("pri_frame_count", 32'(frame_count), 32'd1);
        repeat (20) drive_cycle(1'b1, 1'b0);
        chk_eq("pri_hold", {30'b0, sys_reset, run}, 32'd2);
        apply_reset(1, 1'b1, "pri_rst");
        wait_settle("pri_resettle");
        drain("pri");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
